// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: frame source for the SDRAM-to-VGA write path.
// On each accepted start it emits one raster-ordered frame of RGB565 test
// pattern pixels over a valid/ready handshake, then pulses frame_done.
//
// Ports:
//   clk        in   write-side clock
//   rst        in   synchronous active-high reset
//   start_i    in   single-cycle new-frame request (honoured only in IDLE)
//   mode_i     in   pattern select, latched on an accepted start
//   wr_en      in   downstream ready
//   data_en    out  dout holds a valid pixel
//   dout       out  RGB565 pixel {r[4:0], g[5:0], b[4:0]}
//   busy       out  frame in progress (ACTIVE or DONE)
//   frame_done out  one-cycle pulse after the last pixel transfers
//   frame_cnt  out  completed frames, modulo 256
module vga_pattern_gen #(
  parameter int unsigned H_PIXELS = 1024,
  parameter int unsigned V_LINES  = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  mode_i,
  input  logic        wr_en,
  output logic        data_en,
  output logic [15:0] dout,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned XW = $clog2(H_PIXELS);
  localparam int unsigned YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_mode;
  logic [1:0]    w_mode_nxt;
  logic [XW-1:0] r_x;
  logic [XW-1:0] w_x_nxt;
  logic [YW-1:0] r_y;
  logic [YW-1:0] w_y_nxt;
  logic [15:0]   r_idx;
  logic [15:0]   w_idx_nxt;

  logic          r_data_en;
  logic [15:0]   r_dout;
  logic          r_busy;
  logic          r_frame_done;
  logic [7:0]    r_frame_cnt;

  logic          w_xfer;
  logic [2:0]    w_bar;
  logic          w_y5;
  logic [15:0]   w_pix;

  // data_en is high exactly while ACTIVE, so it doubles as the transfer qualifier
  assign w_xfer = r_data_en & wr_en;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next pixel coordinates
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_ACTIVE;
          w_mode_nxt  = mode_i;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_idx_nxt   = '0;
        end
      end
      S_ACTIVE: begin
        if (w_xfer) begin
          w_idx_nxt = r_idx + 16'd1;
          if (r_x == X_LAST) begin
            w_x_nxt = '0;
            if (r_y == Y_LAST) begin
              w_state_nxt = S_DONE;
            end else begin
              w_y_nxt = r_y + YW'(1);
            end
          end else begin
            w_x_nxt = r_x + XW'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Top three x bits select one of eight equal-width colour bars
  assign w_bar = w_x_nxt[XW-1 -: 3];

  // Frames shorter than 33 lines never reach y bit 5
  generate
    if (YW > 5) begin : g_y5
      assign w_y5 = w_y_nxt[5];
    end else begin : g_no_y5
      assign w_y5 = 1'b0;
    end
  endgenerate

  // Pattern for the pixel that will be presented after this edge
  always_comb begin
    w_pix = 16'h0000;
    case (w_mode_nxt)
      2'd0: begin
        case (w_bar)
          3'd0: w_pix = 16'hFFFF;
          3'd1: w_pix = 16'hFFE0;
          3'd2: w_pix = 16'h07FF;
          3'd3: w_pix = 16'h07E0;
          3'd4: w_pix = 16'hF81F;
          3'd5: w_pix = 16'hF800;
          3'd6: w_pix = 16'h001F;
          3'd7: w_pix = 16'h0000;
        endcase
      end
      2'd1: w_pix = {w_x_nxt[7:3], w_x_nxt[7:2], w_x_nxt[7:3]};
      2'd2: w_pix = (w_x_nxt[5] ^ w_y5) ? 16'hFFFF : 16'h0000;
      default: w_pix = w_idx_nxt;
    endcase
  end

  // Counters, latched mode and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode       <= 2'd0;
      r_x          <= '0;
      r_y          <= '0;
      r_idx        <= 16'd0;
      r_data_en    <= 1'b0;
      r_dout       <= 16'h0000;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 8'd0;
    end else begin
      r_mode       <= w_mode_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_idx        <= w_idx_nxt;
      r_data_en    <= (w_state_nxt == S_ACTIVE);
      r_dout       <= (w_state_nxt == S_ACTIVE) ? w_pix : 16'h0000;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_frame_done <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_DONE) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign data_en    = r_data_en;
  assign dout       = r_dout;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: directed, table-driven bench for vga_pattern_gen.
// Instance a: 256x2 for patterns, handshake, restart and reset behaviour.
// Instance b: default 1024x240 for checkerboard tiles across y bit 5.
// Instance c: 256x1 for 256 back-to-back frames and frame_cnt wrap.
module tb_vga_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_start, a_wr, a_den, a_busy, a_fd;
  logic [1:0]  a_mode;
  logic [15:0] a_dout;
  logic [7:0]  a_fcnt;

  logic        b_rst, b_start, b_wr, b_den, b_busy, b_fd;
  logic [1:0]  b_mode;
  logic [15:0] b_dout;
  logic [7:0]  b_fcnt;

  logic        c_rst, c_start, c_wr, c_den, c_busy, c_fd;
  logic [1:0]  c_mode;
  logic [15:0] c_dout;
  logic [7:0]  c_fcnt;

  vga_pattern_gen #(.H_PIXELS(256), .V_LINES(2)) u_a (
    .clk(clk), .rst(a_rst), .start_i(a_start), .mode_i(a_mode), .wr_en(a_wr),
    .data_en(a_den), .dout(a_dout), .busy(a_busy), .frame_done(a_fd), .frame_cnt(a_fcnt)
  );

  vga_pattern_gen u_b (
    .clk(clk), .rst(b_rst), .start_i(b_start), .mode_i(b_mode), .wr_en(b_wr),
    .data_en(b_den), .dout(b_dout), .busy(b_busy), .frame_done(b_fd), .frame_cnt(b_fcnt)
  );

  vga_pattern_gen #(.H_PIXELS(256), .V_LINES(1)) u_c (
    .clk(clk), .rst(c_rst), .start_i(c_start), .mode_i(c_mode), .wr_en(c_wr),
    .data_en(c_den), .dout(c_dout), .busy(c_busy), .frame_done(c_fd), .frame_cnt(c_fcnt)
  );

  typedef struct {
    logic [1:0]  mode;
    int          idx;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] bars [0:7];
  logic [15:0] cap  [0:1023];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_fcnt = 8'd0;
  int          c_fd_cnt = 0;

  always @(negedge clk) begin
    if (c_fd === 1'b1) c_fd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] m, input int i, input logic [15:0] e);
    vec_t v;
    v.mode = m;
    v.idx  = i;
    v.exp  = e;
    return v;
  endfunction

  task automatic check_table(input logic [1:0] mode);
    foreach (vecs[k]) begin
      if (vecs[k].mode == mode)
        check($sformatf("mode%0d_px%0d", mode, vecs[k].idx), 32'(cap[vecs[k].idx]), 32'(vecs[k].exp));
    end
  endtask

  // One frame on instance a; pixels land in cap[], transfer count in n
  task automatic run_frame_a(input logic [1:0] mode, input bit bp, input bit poke, output int n);
    int          guard;
    int          stab;
    logic [15:0] held;
    a_mode  = mode;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_mode  = ~mode;
    check("start_den", 32'(a_den), 32'd1);
    n = 0;
    guard = 0;
    stab = 0;
    while (a_den === 1'b1 && guard < 4096) begin
      a_wr = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && (guard % 97 == 5)) begin
        a_start = 1'b1;
        a_mode  = 2'd2;
      end else begin
        a_start = 1'b0;
      end
      held = a_dout;
      if (a_wr && n < 1024) begin
        cap[n] = a_dout;
        n++;
      end
      tick();
      if (!a_wr && (a_dout !== held || a_den !== 1'b1)) stab++;
      guard++;
    end
    a_start = 1'b0;
    a_wr    = 1'b1;
    check("frame_timeout", 32'(guard < 4096), 32'd1);
    check("xfer_count", 32'(n), 32'd512);
    check("hold_stable", 32'(stab), 32'd0);
    if (!bp) check("frame_cycles", 32'(guard), 32'd512);
    check("fd_after_last", 32'(a_fd), 32'd1);
    check("busy_in_done", 32'(a_busy), 32'd1);
    exp_fcnt = exp_fcnt + 8'd1;
    check("fcnt", 32'(a_fcnt), 32'(exp_fcnt));
    if (poke) begin
      a_start = 1'b1;
      a_mode  = 2'd0;
    end
    tick();
    a_start = 1'b0;
    check("busy_fall", 32'(a_busy), 32'd0);
    check("fd_fall", 32'(a_fd), 32'd0);
    check("den_idle", 32'(a_den), 32'd0);
    check("fcnt_single_inc", 32'(a_fcnt), 32'(exp_fcnt));
  endtask

  initial begin
    int n;
    int err;

    bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
    bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;

    vecs.push_back(mk(2'd0,   0, 16'hFFFF)); vecs.push_back(mk(2'd0,  31, 16'hFFFF));
    vecs.push_back(mk(2'd0,  32, 16'hFFE0)); vecs.push_back(mk(2'd0,  64, 16'h07FF));
    vecs.push_back(mk(2'd0,  96, 16'h07E0)); vecs.push_back(mk(2'd0, 128, 16'hF81F));
    vecs.push_back(mk(2'd0, 160, 16'hF800)); vecs.push_back(mk(2'd0, 192, 16'h001F));
    vecs.push_back(mk(2'd0, 224, 16'h0000)); vecs.push_back(mk(2'd0, 255, 16'h0000));
    vecs.push_back(mk(2'd0, 256, 16'hFFFF)); vecs.push_back(mk(2'd0, 511, 16'h0000));
    vecs.push_back(mk(2'd1,   0, 16'h0000)); vecs.push_back(mk(2'd1,   4, 16'h0020));
    vecs.push_back(mk(2'd1,   8, 16'h0841)); vecs.push_back(mk(2'd1, 255, 16'hFFFF));
    vecs.push_back(mk(2'd1, 268, 16'h0861));
    vecs.push_back(mk(2'd2,   0, 16'h0000)); vecs.push_back(mk(2'd2,  31, 16'h0000));
    vecs.push_back(mk(2'd2,  32, 16'hFFFF)); vecs.push_back(mk(2'd2,  63, 16'hFFFF));
    vecs.push_back(mk(2'd2,  64, 16'h0000)); vecs.push_back(mk(2'd2, 288, 16'hFFFF));
    vecs.push_back(mk(2'd2, 511, 16'hFFFF));
    vecs.push_back(mk(2'd3,   0, 16'h0000)); vecs.push_back(mk(2'd3, 300, 16'h012C));
    vecs.push_back(mk(2'd3, 511, 16'h01FF));

    // Reset with random inputs on all instances
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    b_start = 1'b0; b_mode = 2'd0; b_wr = 1'b0;
    c_start = 1'b0; c_mode = 2'd0; c_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_start = 1'($urandom_range(0, 1));
      a_mode  = 2'($urandom_range(0, 3));
      a_wr    = 1'($urandom_range(0, 1));
      tick();
    end
    check("rst_den", 32'(a_den), 32'd0);
    check("rst_dout", 32'(a_dout), 32'h0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_fd", 32'(a_fd), 32'd0);
    check("rst_fcnt", 32'(a_fcnt), 32'd0);
    check("rst_b_fcnt", 32'(b_fcnt), 32'd0);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    a_start = 1'b0; a_wr = 1'b1;
    tick();

    // Colour bars, full frame against the bar table
    run_frame_a(2'd0, 1'b0, 1'b0, n);
    check_table(2'd0);
    err = 0;
    for (int i = 0; i < 512; i++) begin
      if (cap[i] !== bars[(i % 256) / 32]) err++;
    end
    check("bars_all_pixels", 32'(err), 32'd0);

    run_frame_a(2'd1, 1'b0, 1'b0, n);
    check_table(2'd1);
    run_frame_a(2'd2, 1'b0, 1'b0, n);
    check_table(2'd2);

    // Address mode under random backpressure
    run_frame_a(2'd3, 1'b1, 1'b0, n);
    check_table(2'd3);
    err = 0;
    for (int i = 0; i < 512; i++) begin
      if (cap[i] !== 16'(i)) err++;
    end
    check("addr_sequence", 32'(err), 32'd0);

    // Start pulses during ACTIVE and in the frame_done cycle are ignored
    run_frame_a(2'd1, 1'b0, 1'b1, n);
    check_table(2'd1);

    // Next-cycle start takes the newly presented mode
    a_mode = 2'd0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_mode = 2'd3;
    check("restart_den", 32'(a_den), 32'd1);
    check("restart_mode0_px0", 32'(a_dout), 32'hFFFF);
    check("restart_busy", 32'(a_busy), 32'd1);

    // Mid-frame reset aborts without a frame_done
    a_wr = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    a_rst = 1'b1;
    tick();
    check("midrst_den", 32'(a_den), 32'd0);
    check("midrst_dout", 32'(a_dout), 32'h0);
    check("midrst_busy", 32'(a_busy), 32'd0);
    check("midrst_fd", 32'(a_fd), 32'd0);
    check("midrst_fcnt", 32'(a_fcnt), 32'd0);
    a_rst = 1'b0;
    tick();
    check("postrst_fd", 32'(a_fd), 32'd0);
    check("postrst_busy", 32'(a_busy), 32'd0);

    fork
      // Checkerboard tiles at default size
      begin : thr_b
        b_mode = 2'd2;
        b_wr = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_mode = 2'd0;
        for (int k = 0; k <= 32800; k++) begin
          if (k == 0)     check("chk_0_0",   32'(b_dout), 32'h0000);
          if (k == 32)    check("chk_32_0",  32'(b_dout), 32'hFFFF);
          if (k == 32768) check("chk_0_32",  32'(b_dout), 32'hFFFF);
          if (k == 32800) check("chk_32_32", 32'(b_dout), 32'h0000);
          tick();
        end
        check("chk_still_active", 32'(b_den), 32'd1);
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        check("chk_rst_busy", 32'(b_busy), 32'd0);
        check("chk_rst_fd", 32'(b_fd), 32'd0);
      end
      // 256 back-to-back frames
      begin : thr_c
        int c_to;
        int c_len_err;
        int c_px0_err;
        int g;
        c_to = 0;
        c_len_err = 0;
        c_px0_err = 0;
        c_mode = 2'd3;
        c_wr = 1'b1;
        for (int f = 0; f < 256; f++) begin
          c_start = 1'b1;
          tick();
          c_start = 1'b0;
          if (c_dout !== 16'h0000 || c_den !== 1'b1) c_px0_err++;
          g = 0;
          while (c_fd !== 1'b1 && g < 400) begin
            tick();
            g++;
          end
          if (g >= 400) c_to++;
          if (g != 256) c_len_err++;
          if (f == 254) check("wrap_fcnt_255", 32'(c_fcnt), 32'd255);
          tick();
        end
        check("wrap_timeouts", 32'(c_to), 32'd0);
        check("wrap_frame_len", 32'(c_len_err), 32'd0);
        check("wrap_px0_index", 32'(c_px0_err), 32'd0);
        check("wrap_fd_pulses", 32'(c_fd_cnt), 32'd256);
        check("wrap_fcnt_0", 32'(c_fcnt), 32'd0);
        check("wrap_idle_busy", 32'(c_busy), 32'd0);
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Frame-data source for the SDRAM-to-VGA path. It produces one frame of RGB565 test-pattern pixels per start request and feeds them over a valid/ready handshake into the memory write side, which runs on the 50 MHz write clock. A start request comes from the memory side's new-frame indication. The block supports four selectable patterns and keeps a count of completed frames. Pixel order is raster: x varies fastest, then y.

## Interface
Parameters:
- H_PIXELS, 1024: pixels per line. Must be a power of two and ≥ 256.
- V_LINES, 240: lines per frame. Frame size is H_PIXELS*V_LINES, which equals DATA_DEPTH at top level.

Ports:
- clk  in  1  single clock (50 MHz write clock)
- rst  in  1  synchronous, active-high reset
- start_i  in  1  single-cycle request to generate a new frame
- mode_i  in  2  pattern select, latched when a start is accepted
- wr_en  in  1  downstream ready (memory can accept a write)
- data_en  out  1  dout holds a valid pixel
- dout  out  16  pixel, RGB565 {r[4:0], g[5:0], b[4:0]}
- busy  out  1  a frame is in progress (ACTIVE or DONE)
- frame_done  out  1  one-cycle pulse after the last pixel of a frame transfers
- frame_cnt  out  8  completed frames, wraps from 255 to 0

Clocking: one clock; reset is synchronous and active-high, on ports clk / rst.

## Operation
- State machine: IDLE, ACTIVE, DONE.
- IDLE:
  - data_en=0 and busy=0.
  - When start_i=1, latch mode_i, clear x, y and the linear index, and go to ACTIVE.
- ACTIVE:
  - data_en=1 and dout holds the pixel at (x,y).
  - A transfer occurs on a rising edge where data_en=1 and wr_en=1.
  - On a transfer, x increments. When x=H_PIXELS-1, x wraps to 0 and y increments. The linear index increments by 1 on every transfer, 16-bit wrap.
  - A transfer at (H_PIXELS-1, V_LINES-1) moves the block to DONE.
- DONE: lasts exactly one cycle. frame_done=1, frame_cnt increments, and the next state is IDLE.
- start_i is ignored in ACTIVE and DONE. It is not queued.
- While wr_en=0, dout and data_en hold stable and no counters advance.
- Patterns, selected by the latched mode:
  - 0, colour bars: 8 bars. bar = x[log2(H_PIXELS)-1 -: 3]. Colours for bars 0..7: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1, grey ramp: {x[7:3], x[7:2], x[7:3]}. Repeats every 256 pixels.
  - 2, checkerboard with 32x32 tiles: (x[5]^y[5]) ? FFFF : 0000.
  - 3, address: linear pixel index [15:0] = (y*H_PIXELS+x) mod 65536. Implemented as a counter; no multiplier.
- Reset, including mid-frame: abort the frame, go to IDLE. data_en=0, dout=0000, busy=0, frame_done=0, frame_cnt=0, internal counters=0. No partial-frame frame_done is issued.

## Timing
- All outputs are registered.
- start_i sampled high at edge N gives data_en=1 and pixel (0,0) valid after edge N.
- After each transfer edge, the next pixel is on dout after that same edge. With wr_en held high, throughput is 1 pixel per clock and there are no bubbles.
- With wr_en constantly 1, a frame is exactly H_PIXELS*V_LINES cycles of data_en=1.
  - data_en falls, busy stays 1 and frame_done=1, all after the last transfer edge.
  - busy falls one cycle later.
- A start_i that arrives in the same cycle as frame_done is ignored. The earliest accepted new start is sampled in the cycle after frame_done, in IDLE.
- Counter widths:
  - x: log2(H_PIXELS) bits.
  - y: ceil(log2(V_LINES)) bits.
  - index: 16 bits.
  - frame_cnt: 8 bits, modulo arithmetic.

## Test plan
- Reset: hold rst=1 for 3 cycles with random inputs. Required: data_en=0, dout=0000, busy=0, frame_done=0, frame_cnt=0. Assert rst mid-frame and require the same values on the next edge, with no frame_done.
- Colour bars (H_PIXELS=256, V_LINES=2), mode 0, wr_en=1. Required:
  - Pixels 0–31 are FFFF, 32–63 are FFE0, …, 224–255 are 0000. Line 2 repeats.
  - Exactly 512 transfers, frame_done on the cycle after the 512th, frame_cnt=1.
- Backpressure: mode 3 with wr_en driven by a random 50% pattern. Required: the transferred sequence is 0,1,2,…,511 with no duplicates or gaps, and dout is stable whenever wr_en=0.
- Checkerboard at default size, mode 2, sampled at (0,0), (32,0), (0,32), (32,32). Required values: FFFF is never at (0,0); the four values are 0000, FFFF, FFFF, 0000. 245760 transfers in total, and the last address-mode value would be 0xBFFF.
- start_i pulses during ACTIVE and in the frame_done cycle. Required: no restart, no extra frame, frame_cnt increments by 1. A start the following cycle begins a new frame with the newly latched mode.
- 256 back-to-back small frames. Required: frame_cnt wraps 255→0 and frame_done pulses exactly 256 times.
